// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes only from registered state, so no combinational path runs
// from out_ready back to in_ready. The write-back value is selected and
// register-0 writes are suppressed at capture time.
module mem_wb_skid_stage #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned REG_BITS     = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_data_addr,
  input  logic [DATA_WIDTH-1:0]   in_load_data,
  input  logic                    in_regWrite,
  input  logic                    in_memRead,
  input  logic [REG_BITS-1:0]     in_rd,
  input  logic [DATA_WIDTH-1:0]   in_ALU_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_data_addr,
  output logic [DATA_WIDTH-1:0]   out_wb_data,
  output logic                    out_regWrite,
  output logic                    out_memRead,
  output logic [REG_BITS-1:0]     out_rd,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic                    regwrite;
    logic                    memread;
    logic [REG_BITS-1:0]     rd;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  // Build the stored form of the incoming entry: pick write-back data and gate rd==0 writes.
  always_comb begin
    in_entry          = '0;
    in_entry.addr     = in_data_addr;
    in_entry.wb_data  = in_memRead ? in_load_data : in_ALU_result;
    in_entry.regwrite = in_regWrite & (in_rd != '0);
    in_entry.memread  = in_memRead;
    in_entry.rd       = in_rd;
  end

  // Handshake and status outputs, all derived from registered state (plus reset for in_ready).
  always_comb begin
    in_ready  = (state_q != ST_FULL) & ~reset;
    out_valid = (state_q != ST_EMPTY);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    out_data_addr = main_q.addr;
    out_wb_data   = main_q.wb_data;
    out_regWrite  = main_q.regwrite & out_valid;
    out_memRead   = main_q.memread;
    out_rd        = main_q.rd;
  end

  // Next-state and payload movement; flush overrides the state but leaves payload stale.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_entry;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_d  = in_entry;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // State and payload registers; reset clears everything and beats flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised MEM/WB pipeline stage that replaces the plain always-latching MEM/WB register.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and reset, and write-back data selection.
- Sits between the data-memory interface and the register-file write port.
- Lets a variable-latency memory or a stalled write-back stall cleanly, with no combinational ready path through the stage.

Parameters:
DATA_WIDTH, 32, width of load data, ALU result and write-back data
ADDRESS_BITS, 20, width of data address
REG_BITS, 5, width of destination register index

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept an entry this cycle
in_data_addr  input  ADDRESS_BITS  memory address of the entry
in_load_data  input  DATA_WIDTH  data returned by the load
in_regWrite  input  1  entry writes the register file
in_memRead  input  1  entry is a load
in_rd  input  REG_BITS  destination register
in_ALU_result  input  DATA_WIDTH  ALU result
out_valid  output  1  downstream entry present
out_ready  input  1  downstream accepts the entry this cycle
out_data_addr  output  ADDRESS_BITS  buffered address
out_wb_data  output  DATA_WIDTH  selected write-back value
out_regWrite  output  1  gated register write enable
out_memRead  output  1  buffered memRead
out_rd  output  REG_BITS  buffered destination register
occupancy  output  2  number of valid entries (0..2)

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state changes on posedge clock only.
- Storage: main entry (drives the out_* ports) and skid entry.
- Stored payload per entry: addr, wb_data, regWrite_eff, memRead, rd.
- wb_data = in_memRead ? in_load_data : in_ALU_result, selected at capture.
- regWrite_eff = in_regWrite & (in_rd != 0); writes to register 0 are suppressed.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE: in_fire & out_fire -> ONE, main <= in. in_fire & !out_fire -> FULL, skid <= in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: out_fire -> ONE, main <= skid. Otherwise hold. No capture is possible in FULL.
- in_ready:
  - Equals (state != FULL) & !reset.
  - Depends only on registered state; there is no path from out_ready.
- out_valid = (state != EMPTY).
- out_regWrite = main.regWrite_eff & out_valid. It is never high while out_valid is low.
- Latency and throughput:
  - 1 cycle from in_fire in EMPTY to out_valid.
  - Sustains 1 entry per cycle while out_ready is held high.
- Ordering: strictly FIFO; skid never overtakes main.
- Flush:
  - Next state EMPTY.
  - Any entry accepted in the same cycle is discarded.
  - Payload registers may hold stale values, but out_regWrite must be 0.
  - An out_fire in the flush cycle still counts as consumed downstream.
- Reset:
  - Priority over flush and all handshakes.
  - State EMPTY; all payload registers 0; every output 0 (in_ready 0 while reset is high).
  - in_ready rises to 1 in the first cycle after reset deasserts.
  - Reset mid-operation drops all entries.
- Idle: out_* values hold stable while out_valid & !out_ready (no change on stall).

Test Plan:
- Reset with in_valid=1 -> in_ready=0 and all outputs 0 during reset; in_ready=1, occupancy=0 the cycle after release.
- Stream 4 entries (ALU_result 0x11,0x22,0x33,0x44, memRead=0, rd=3), out_ready=1 -> out_wb_data 0x11..0x44 on consecutive cycles, 1-cycle latency, occupancy stays 1.
- out_ready=0, push load entries A (load_data 0xA5, memRead=1) and B -> occupancy 2, in_ready=0, out holds A. out_ready=1 -> A then B delivered in order, in_ready=1 the cycle after A leaves.
- In FULL, pulse flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_regWrite=0; the offered entry is not delivered.
- Entry with regWrite=1, rd=0, ALU_result 0xDEAD -> out_valid=1, out_wb_data=0xDEAD, out_regWrite=0. Same entry with rd=7 -> out_regWrite=1.
- In ONE, simultaneous in_fire and out_fire for 10 cycles -> state stays ONE, every entry delivered exactly once; assert reset mid-stream -> all outputs 0 the next cycle.
